// File: rtl/pool_window_scheduler_pkg.sv
// pool_window_scheduler_pkg: FSM encoding, tap geometry and default widths shared by the scheduler
package pool_window_scheduler_pkg;
  localparam int TAPS = 9;
  localparam int BIT_WIDTH_D = 8;
  localparam int DIM_W_D = 6;
  localparam int ADDR_W_D = 12;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, POOL, EMIT} state_e;
  // tap k sits at row k/3 and column k%3 of the 3x3 window, 1 being the centre
  function automatic logic [1:0] tap_row(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction
  function automatic logic [1:0] tap_col(input logic [3:0] k);
    return 2'(k % 4'd3);
  endfunction
endpackage

// File: rtl/pool_window_scheduler_maxpool.sv
// pool_window_scheduler_maxpool: unsigned max over the unmasked taps of a 3x3 window
module pool_window_scheduler_maxpool
  import pool_window_scheduler_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_D
) (
  input  logic [TAPS*BIT_WIDTH-1:0] taps_i,
  input  logic [TAPS-1:0]           mask_i,
  output logic [BIT_WIDTH-1:0]      max_o
);
  always_comb begin
    max_o = '0;
    for (int j = 0; j < TAPS; j++)
      max_o = mask_i[j] && taps_i[j*BIT_WIDTH +: BIT_WIDTH] > max_o ? taps_i[j*BIT_WIDTH +: BIT_WIDTH] : max_o;
  end
endmodule

// File: rtl/pool_window_scheduler.sv
// pool_window_scheduler: walks 3x3 windows over a feature map, fetches the in-map taps,
// max-pools them and hands each result out over a valid/ready port
module pool_window_scheduler
  import pool_window_scheduler_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_D,
  parameter int DIM_W = DIM_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic                 cfg_stride2,
  input  logic [ADDR_W-1:0]    cfg_src_base,
  input  logic [ADDR_W-1:0]    cfg_dst_base,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [BIT_WIDTH-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 busy,
  output logic                 done
);
  state_e state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q, r_q, c_q;
  logic s2_q;
  logic [ADDR_W-1:0] src_q, dst_q, ord_q, out_addr_q;
  logic [BIT_WIDTH-1:0] out_data_q, pool_max;
  logic [BIT_WIDTH-1:0] tap_q [TAPS];
  logic [TAPS*BIT_WIDTH-1:0] tap_flat;
  logic [3:0] k_q, cap_k_q;
  logic cap_q, cap_m_q, done_q;
  logic [TAPS-1:0] mask;
  logic [DIM_W:0] r_nx, c_nx, rr, cc;
  logic zero_cfg, last, hs, r_lo, r_hi, c_lo, c_hi;
  assign zero_cfg = cfg_width == '0 || cfg_height == '0;
  assign hs = state_q == EMIT && out_ready;
  assign r_nx = {1'b0, r_q} + (s2_q ? (DIM_W+1)'(2) : (DIM_W+1)'(1));
  assign c_nx = {1'b0, c_q} + (s2_q ? (DIM_W+1)'(2) : (DIM_W+1)'(1));
  assign last = r_nx >= {1'b0, h_q} && c_nx >= {1'b0, w_q};
  assign r_lo = r_q != '0;
  assign c_lo = c_q != '0;
  assign r_hi = {1'b0, r_q} + (DIM_W+1)'(1) < {1'b0, h_q};
  assign c_hi = {1'b0, c_q} + (DIM_W+1)'(1) < {1'b0, w_q};
  always_comb begin
    for (int j = 0; j < TAPS; j++)
      mask[j] = (tap_row(4'(j)) != 2'd0 || r_lo) && (tap_row(4'(j)) != 2'd2 || r_hi) &&
                (tap_col(4'(j)) != 2'd0 || c_lo) && (tap_col(4'(j)) != 2'd2 || c_hi);
  end
  // only meaningful for in-map taps, where the offset row/column cannot underflow
  assign rr = {1'b0, r_q} + (DIM_W+1)'(tap_row(k_q)) - (DIM_W+1)'(1);
  assign cc = {1'b0, c_q} + (DIM_W+1)'(tap_col(k_q)) - (DIM_W+1)'(1);
  for (genvar t = 0; t < TAPS; t++) begin : g_flat
    assign tap_flat[t*BIT_WIDTH +: BIT_WIDTH] = tap_q[t];
  end
  pool_window_scheduler_maxpool #(.BIT_WIDTH(BIT_WIDTH)) u_maxpool (
    .taps_i(tap_flat),
    .mask_i(mask),
    .max_o (pool_max)
  );
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && !zero_cfg ? FETCH : IDLE;
      FETCH:   state_d = k_q == 4'd8 ? DRAIN : FETCH;
      DRAIN:   state_d = POOL;
      POOL:    state_d = EMIT;
      EMIT:    state_d = hs ? (last ? IDLE : FETCH) : EMIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    out_valid = state_q == EMIT;
    rd_en = state_q == FETCH && mask[k_q];
    rd_addr = rd_en ? src_q + ADDR_W'(rr) * ADDR_W'(w_q) + ADDR_W'(cc) : '0;
  end
  assign done = done_q;
  assign out_data = out_data_q;
  assign out_addr = out_addr_q;
  // cap_* remembers last cycle's read so its data lands in the right tap; cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      {w_q, h_q, r_q, c_q, s2_q} <= '0;
      {src_q, dst_q, ord_q, out_addr_q, out_data_q} <= '0;
      {k_q, cap_k_q, cap_q, cap_m_q, done_q} <= '0;
      for (int j = 0; j < TAPS; j++) tap_q[j] <= '0;
    end else begin
      done_q <= (state_q == IDLE && start && zero_cfg) || (hs && last);
      cap_q <= state_q == FETCH;
      cap_k_q <= k_q;
      cap_m_q <= rd_en;
      if (cap_q) tap_q[cap_k_q] <= cap_m_q ? rd_data : '0;
      if (state_q == IDLE && start) begin
        {w_q, h_q, s2_q, src_q, dst_q} <= {cfg_width, cfg_height, cfg_stride2, cfg_src_base, cfg_dst_base};
        {r_q, c_q, k_q, ord_q} <= '0;
      end
      if (state_q == FETCH) k_q <= k_q + 4'd1;
      if (state_q == POOL) begin
        out_data_q <= pool_max;
        out_addr_q <= dst_q + ord_q;
      end
      if (hs) begin
        k_q <= '0;
        ord_q <= ord_q + ADDR_W'(1);
        c_q <= c_nx >= {1'b0, w_q} ? '0 : c_nx[DIM_W-1:0];
        r_q <= c_nx >= {1'b0, w_q} ? r_nx[DIM_W-1:0] : r_q;
      end
    end
  end
endmodule

// File: tb/tb_pool_window_scheduler.sv
// tb_pool_window_scheduler: directed and randomized passes checked against a window-level reference model
module tb_pool_window_scheduler;
  localparam int BW = 8;
  localparam int DW = 6;
  localparam int AW = 12;
  logic clk = 0, reset = 0, start = 0;
  logic [DW-1:0] cfg_width = '0, cfg_height = '0;
  logic cfg_stride2 = 0;
  logic [AW-1:0] cfg_src_base = '0, cfg_dst_base = '0;
  logic rd_en, out_valid, busy, done;
  logic out_ready = 1;
  logic [AW-1:0] rd_addr, out_addr;
  logic [BW-1:0] rd_data = '0, out_data;
  logic [BW-1:0] mem [4096];
  int n_checks = 0, n_errors = 0;
  int exp_rd[$], exp_od[$], exp_oa[$];
  int got_data [64];
  int got_rds [64];
  int hs_cnt, win_rds, cyc, nw;
  bit mon_en = 0, mon_first = 0, zero_pass = 0, exp_done = 0, stall_prev = 0;
  logic [BW-1:0] prev_d;
  logic [AW-1:0] prev_a;
  always #5 clk = ~clk;
  pool_window_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride2(cfg_stride2),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
  );
  // one-cycle read latency; garbage when no read so masked taps cannot borrow stale data
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : BW'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build(input int w, input int h, input int s2, input int src, input int dst, output int nwin);
    int s, mx, rr, cc, a;
    exp_rd.delete(); exp_od.delete(); exp_oa.delete();
    nwin = 0;
    s = s2 ? 2 : 1;
    for (int r = 0; r < h; r += s)
      for (int c = 0; c < w; c += s) begin
        mx = 0;
        for (int k = 0; k < 9; k++) begin
          rr = r + k / 3 - 1;
          cc = c + k % 3 - 1;
          if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
            a = (src + rr * w + cc) % 4096;
            exp_rd.push_back(a);
            if (int'(mem[a]) > mx) mx = int'(mem[a]);
          end
        end
        exp_od.push_back(mx);
        exp_oa.push_back((dst + nwin) % 4096);
        nwin++;
      end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("done", done, exp_done);
        exp_done = mon_first ? zero_pass : 0;
        mon_first = 0;
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_d);
          check("hold_addr", out_addr, prev_a);
        end
        if (rd_en) begin
          if (exp_rd.size() == 0) check("rd_extra", rd_en, 0);
          else begin
            check("rd_addr", rd_addr, exp_rd.pop_front());
            win_rds++;
          end
        end
        if (out_valid && out_ready) begin
          if (exp_od.size() == 0) check("out_extra", out_valid, 0);
          else begin
            check("out_data", out_data, exp_od.pop_front());
            check("out_addr", out_addr, exp_oa.pop_front());
            got_data[hs_cnt % 64] = int'(out_data);
            got_rds[hs_cnt % 64] = win_rds;
            win_rds = 0;
            hs_cnt++;
            if (exp_od.size() == 0) exp_done = 1;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_a = out_addr;
      end
    end
  endtask

  task automatic start_pass(input int w, input int h, input int s2, input int src, input int dst);
    build(w, h, s2, src, dst, nw);
    hs_cnt = 0; win_rds = 0; stall_prev = 0; out_ready = 1;
    zero_pass = nw == 0; exp_done = 0; mon_first = 1;
    @(posedge clk); #2;
    cfg_width = DW'(w); cfg_height = DW'(h); cfg_stride2 = s2[0];
    cfg_src_base = AW'(src); cfg_dst_base = AW'(dst);
    start = 1;
    mon_en = 1;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles at the first result
  task automatic run_pass(input int w, input int h, input int s2, input int src, input int dst,
                          input int mode, output int cycles);
    int n, hold;
    bit stalled;
    repeat (2) @(posedge clk);
    start_pass(w, h, s2, src, dst);
    n = 0; hold = 0; stalled = 0;
    do begin
      @(posedge clk); #2;
      n++;
      start = n == 4 && nw > 0;
      if (n == 4 && nw > 0) begin
        cfg_width = DW'($urandom); cfg_height = DW'($urandom); cfg_stride2 = 1'($urandom);
        cfg_src_base = AW'($urandom); cfg_dst_base = AW'($urandom);
      end
      if (mode == 1) out_ready = $urandom_range(0, 2) != 0;
      if (mode == 2) begin
        if (!stalled && out_valid) begin
          stalled = 1; hold = 5; out_ready = 0;
        end else if (hold > 0) begin
          hold--;
          out_ready = hold == 0;
        end
      end
      check("busy", busy, !done);
    end while (!done && n < 20000);
    check("timeout", done, 1);
    start = 0;
    cycles = n;
    @(negedge clk);
    @(negedge clk);
    #1;
    mon_en = 0;
    out_ready = 1;
    check("rd_left", exp_rd.size(), 0);
    check("out_left", exp_od.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, out_addr, 0);
  endtask

  initial begin
    int w, h, s2, s, n;
    fork monitor(); join_none
    for (int i = 0; i < 4096; i++) mem[i] = BW'(i);
    repeat (3) @(posedge clk);
    #2;
    check_zero("rst");
    reset = 1;
    run_pass(4, 4, 0, 0, 'h10, 0, cyc);
    check("s1_outs", hs_cnt, 16);
    check("s1_cycles", cyc, 12 * 16 + 1);
    check("w00_val", got_data[0], 5);
    check("w00_reads", got_rds[0], 4);
    check("w33_val", got_data[15], 15);
    run_pass(5, 5, 1, 0, 'h100, 0, cyc);
    check("s2_outs", hs_cnt, 9);
    check("s2_cycles", cyc, 12 * 9 + 1);
    check("w22_reads", got_rds[4], 9);
    run_pass(0, 4, 0, 0, 0, 0, cyc);
    check("zero_cycles", cyc, 1);
    check("zero_outs", hs_cnt, 0);
    run_pass(3, 3, 0, 7, 'h20, 2, cyc);
    check("stall_outs", hs_cnt, 9);
    check("stall_cycles", cyc, 12 * 9 + 1 + 5);
    repeat (2) @(posedge clk);
    start_pass(4, 4, 0, 0, 0);
    @(posedge clk); #2;
    start = 0;
    n = 0;
    while (hs_cnt < 3 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_reach", hs_cnt, 3);
    repeat (3) @(posedge clk);
    #2;
    check("mid_fetch_busy", busy, 1);
    mon_en = 0;
    reset = 0;
    @(posedge clk); #2;
    check_zero("midrst");
    reset = 1;
    run_pass(4, 4, 0, 0, 0, 0, cyc);
    check("rerun_outs", hs_cnt, 16);
    check("rerun_w00", got_data[0], 5);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4096; i++) mem[i] = BW'($urandom);
      w = $urandom_range(1, 9);
      h = $urandom_range(1, 9);
      s2 = $urandom_range(0, 1);
      s = s2 ? 2 : 1;
      run_pass(w, h, s2, $urandom_range(0, 4095), $urandom_range(0, 4095), 1, cyc);
      check("rnd_outs", hs_cnt, ((w + s - 1) / s) * ((h + s - 1) / s));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
